prio_encoder_hs: RTL and testbench
==================================

Name: prio_encoder_hs

Overview:
- Parametrised N-to-log2(N) priority encoder with registered output and valid/ready handshakes on both sides.
- Successor to the fixed 4-to-2 one-hot encoder. Accepts arbitrary (multi-hot or zero) request vectors and reports the winning index plus none/multi flags.
- Holds the result under output backpressure and keeps a saturating count of encoded events.
- Sits between request sources (interrupt lines, arbiter requesters) and a downstream consumer.

Parameters:
- N, 4, number of request inputs; legal range 2..64.
- IDX_W, $clog2(N), width of out_idx; derived, do not override.
- CNT_W, 8, width of the event counter enc_count.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_req is valid this cycle.
- in_ready  output  1  block can accept in_req this cycle.
- in_req  input  N  request vector; bit i = requester i.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- out_idx  output  IDX_W  winning request index.
- out_none  output  1  accepted vector was all-zero.
- out_multi  output  1  accepted vector had 2 or more bits set.
- enc_count  output  CNT_W  saturating count of accepted nonzero vectors.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk. The block has one clock and no asynchronous reset. Reset values:
  - out_valid = 0, out_idx = 0, out_none = 0, out_multi = 0.
  - enc_count = 0; round-robin pointer = 0.
  - rst overrides all other inputs in the same cycle.
  - Reset mid-transaction discards the held result with no completion.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single-entry pipeline, full throughput).
  - Accept occurs when in_valid && in_ready.
  - Latency 1: results are registered on the accept edge; out_valid = 1 from the next cycle.
  - When out_valid && !out_ready: out_idx, out_none, out_multi and out_valid are held stable; in_ready = 0.
  - When out_valid && out_ready && !in_valid: out_valid -> 0 next cycle; data registers keep their old values.
  - When out_valid && out_ready && in_valid: back-to-back accept; out_valid stays 1 with the new result.
- Encoding (fixed priority, default): lowest set index wins.
- Zero vector: out_idx = 0, out_none = 1, out_multi = 0; the result is still delivered with out_valid = 1.
- out_multi = 1 when popcount(in_req) >= 2. The winner is still reported.
- enc_count:
  - +1 on each accept with in_req != 0.
  - Saturates at 2^CNT_W - 1; never wraps.
  - Not affected by out_ready.
- in_req is ignored whenever no accept occurs.

Optional Feature:
- Macro: PRIO_ENCODER_HS_ROUND_ROBIN_EN.
- Defined:
  - Search starts at internal pointer ptr and scans upward, wrapping N-1 -> 0. The first set bit wins.
  - On each accept with in_req != 0, ptr <= (winner + 1) mod N.
  - ptr is unchanged on zero vectors and on non-accept cycles.
  - ptr resets to 0, so the first decision after reset equals fixed priority.
- Not defined:
  - Fixed lowest-index priority; no pointer register is built.

Test Plan:
1. Reset then idle: rst = 1 for 2 cycles -> out_valid = 0, enc_count = 0, in_ready = 1.
2. One-hot sweep, N = 4, out_ready = 1: in_req = 0001, 0010, 0100, 1000 on consecutive cycles -> out_idx = 0, 1, 2, 3, each 1 cycle after accept; out_none = 0, out_multi = 0; enc_count = 4. Then in_req = 0000 -> out_idx = 0, out_none = 1, enc_count stays 4.
3. Multi-hot, fixed priority: in_req = 1010 -> out_idx = 1, out_multi = 1. Then in_req = 1100 -> out_idx = 2, out_multi = 1.
4. Backpressure:
   - Accept in_req = 0100, then hold out_ready = 0 for 3 cycles while in_valid = 1 with in_req = 0001.
   - Required: out_idx stays 2, in_ready = 0 throughout, enc_count unchanged.
   - Raise out_ready -> 0001 is accepted that cycle; out_idx = 0 next cycle.
5. Saturation, CNT_W = 3: 9 accepts of 0001 -> enc_count = 7 and holds at 7.
6. ROUND_ROBIN_EN defined, N = 4: in_req = 1111 accepted 5 times -> out_idx = 0, 1, 2, 3, 0. Then rst mid-stream with out_valid = 1 -> out_valid = 0 next cycle; the next 1111 gives out_idx = 0.

Source files
------------

// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs: parametrised N-to-log2(N) priority encoder with a registered
// result, valid/ready handshakes on both sides, none/multi flags and a
// saturating count of accepted nonzero request vectors.
//
// Optional build macro: PRIO_ENCODER_HS_ROUND_ROBIN_EN
//   undefined (default) - fixed priority, lowest set index wins.
//   defined             - round-robin search starting at an internal pointer
//                         that advances past each winner.
module prio_encoder_hs #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_none,
    output logic             out_multi,
    output logic [CNT_W-1:0] enc_count
);

    // Lowest set bit index; zero when no bit is set.
    function automatic logic [IDX_W-1:0] find_lowest(input logic [N-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) r = IDX_W'(i);
        end
        return r;
    endfunction

    // First set bit scanning upward from start, wrapping N-1 -> 0; zero when empty.
    function automatic logic [IDX_W-1:0] find_from(input logic [N-1:0]     v,
                                                   input logic [IDX_W-1:0] start);
        logic [IDX_W-1:0] r;
        int               j;
        r = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N;
            if (v[j]) r = IDX_W'(j);
        end
        return r;
    endfunction

    // Two or more bits set: clearing the lowest set bit leaves something behind.
    function automatic logic is_multi(input logic [N-1:0] v);
        return (v & (v - N'(1))) != '0;
    endfunction

    // Saturating increment; holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    // Index following w, wrapping N-1 -> 0 (N need not be a power of two).
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] w);
        return (w == IDX_W'(N - 1)) ? '0 : w + IDX_W'(1);
    endfunction

    logic             vld_p1;
    logic [IDX_W-1:0] idx_p1;
    logic             none_p1;
    logic             multi_p1;
    logic [CNT_W-1:0] cnt_p1;

    logic             accept;
    logic             req_nz;
    logic [IDX_W-1:0] win_p0;

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;
    assign req_nz   = in_req != '0;

`ifdef PRIO_ENCODER_HS_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr;

    // Winner selection: search starts at the round-robin pointer.
    always_comb begin
        win_p0 = find_from(in_req, ptr);
    end

    // Pointer moves just past the winner on every nonzero accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept && req_nz) begin
            ptr <= next_idx(win_p0);
        end
    end
`else
    // Winner selection: fixed priority, lowest index first.
    always_comb begin
        win_p0 = find_lowest(in_req);
    end
`endif

    // ---- stage p0 -> p1: result register with hold under backpressure ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            idx_p1   <= '0;
            none_p1  <= 1'b0;
            multi_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1   <= 1'b1;
            idx_p1   <= win_p0;
            none_p1  <= !req_nz;
            multi_p1 <= is_multi(in_req);
        end else if (out_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    // Event counter: counts accepted nonzero vectors, independent of out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p1 <= '0;
        end else if (accept && req_nz) begin
            cnt_p1 <= sat_inc(cnt_p1);
        end
    end

    assign out_valid = vld_p1;
    assign out_idx   = idx_p1;
    assign out_none  = none_p1;
    assign out_multi = multi_p1;
    assign enc_count = cnt_p1;

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Testbench for prio_encoder_hs (N = 4, CNT_W = 3). A behavioural model
// tracks the required outputs and is compared on every falling edge; directed
// steps also carry hand-computed literal expectations.
module tb_prio_encoder_hs;

    localparam int N     = 4;
    localparam int IDX_W = 2;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_req;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_none;
    logic             out_multi;
    logic [CNT_W-1:0] enc_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    prio_encoder_hs #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_req    (in_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_multi (out_multi),
        .enc_count (enc_count)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit m_vld;
    int m_idx;
    bit m_none;
    bit m_multi;
    int m_cnt;
    int m_ptr;

    // Winner: rotate the request so the search start sits at bit 0, take the
    // lowest set bit, then undo the rotation.
    function automatic int model_winner(input logic [N-1:0] req, input int start);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        logic [N-1:0]   lsb;
        dbl = {req, req};
        rot = N'(dbl >> start);
        if (rot == '0) return 0;
        lsb = rot & (~rot + N'(1));
        return ($clog2(lsb) + start) % N;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_vld = 0; m_idx = 0; m_none = 0; m_multi = 0; m_cnt = 0; m_ptr = 0;
        end else if (in_valid && (!m_vld || out_ready)) begin
            m_vld   = 1;
            m_idx   = model_winner(in_req, m_ptr);
            m_none  = (in_req == '0);
            m_multi = ($countones(in_req) >= 2);
            if (in_req != '0) begin
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
`ifdef PRIO_ENCODER_HS_ROUND_ROBIN_EN
                m_ptr = (m_idx + 1) % N;
`endif
            end
        end else if (out_ready) begin
            m_vld = 0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("model.out_valid", 64'(out_valid), 64'(m_vld));
            check("model.in_ready",  64'(in_ready),  64'(!m_vld || out_ready));
            check("model.out_idx",   64'(out_idx),   64'(m_idx));
            check("model.out_none",  64'(out_none),  64'(m_none));
            check("model.out_multi", 64'(out_multi), 64'(m_multi));
            check("model.enc_count", 64'(enc_count), 64'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_req = '0; out_ready = 1'b1;

        // Reset then idle
        tick(); tick();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.enc_count", 64'(enc_count), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd1);

        // One-hot sweep, then a zero vector
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1; in_req = N'(1 << i);
            tick();
            check("sweep.out_idx",   64'(out_idx),   64'(i));
            check("sweep.out_valid", 64'(out_valid), 64'd1);
            check("sweep.out_multi", 64'(out_multi), 64'd0);
        end
        check("sweep.enc_count", 64'(enc_count), 64'd4);
        in_req = '0;
        tick();
        check("zero.out_none",  64'(out_none),  64'd1);
        check("zero.out_idx",   64'(out_idx),   64'd0);
        check("zero.enc_count", 64'(enc_count), 64'd4);
        in_valid = 1'b0;
        tick();
        check("drain.out_valid", 64'(out_valid), 64'd0);

        // Multi-hot vectors
        in_valid = 1'b1; in_req = 4'b1010;
        tick();
        check("multi1.out_idx",   64'(out_idx),   64'd1);
        check("multi1.out_multi", 64'(out_multi), 64'd1);
        in_req = 4'b1100;
        tick();
        check("multi2.out_idx",   64'(out_idx),   64'd2);
        check("multi2.out_multi", 64'(out_multi), 64'd1);
        in_valid = 1'b0;
        tick();

        // Backpressure: result held, input stalled, count frozen
        pulse_reset();
        in_valid = 1'b1; in_req = 4'b0100;
        tick();
        out_ready = 1'b0; in_req = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp.out_idx",   64'(out_idx),   64'd2);
            check("bp.out_valid", 64'(out_valid), 64'd1);
            check("bp.in_ready",  64'(in_ready),  64'd0);
            check("bp.enc_count", 64'(enc_count), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 64'(in_ready), 64'd1);
        tick();
        check("bp.after_idx",   64'(out_idx),   64'd0);
        check("bp.after_count", 64'(enc_count), 64'd2);
        in_valid = 1'b0;
        tick();

        // Counter saturation at 2^CNT_W - 1
        pulse_reset();
        in_valid = 1'b1; in_req = 4'b0001;
        for (int i = 0; i < 9; i++) tick();
        check("sat.enc_count", 64'(enc_count), 64'd7);
        in_valid = 1'b0;
        tick();
        check("sat.hold", 64'(enc_count), 64'd7);

        // All-requesters vector, then reset while a result is held
        pulse_reset();
        in_valid = 1'b1; in_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
`ifdef PRIO_ENCODER_HS_ROUND_ROBIN_EN
            check("rr.out_idx", 64'(out_idx), 64'(i % 4));
`else
            check("fixed.out_idx", 64'(out_idx), 64'd0);
`endif
            check("all.out_multi", 64'(out_multi), 64'd1);
        end
        rst = 1'b1;
        tick();
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.enc_count", 64'(enc_count), 64'd0);
        rst = 1'b0;
        tick();
        check("postrst.out_idx",   64'(out_idx),   64'd0);
        check("postrst.out_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
